// File: rtl/gpca.sv
// GPCA: 7-row pipelined multiply / square / divide / square-root array, 7-cycle latency.
// Define GPCA_ACCUM_EN to add the A operand in multiply and square modes.
module gpca (
    input  logic        clk,
    input  logic        rst,
    input  logic        X,
    input  logic [1:7]  P,
    input  logic [1:9]  B,
    input  logic [1:9]  C,
    input  logic [1:14] A,
    output logic [1:7]  F,
    output logic [1:15] S
);

    localparam logic [1:0] MODE_MUL  = 2'b00;
    localparam logic [1:0] MODE_SQR  = 2'b01;
    localparam logic [1:0] MODE_DIV  = 2'b10;
    localparam logic [1:0] MODE_SQRT = 2'b11;

    typedef struct packed {
        logic [1:0]  mode;
        logic        ovf;
        logic [6:0]  p;
        logic [8:0]  m;
        logic [16:0] acc;
        logic [6:0]  q;
`ifdef GPCA_ACCUM_EN
        logic [13:0] a;
`endif
    } stage_t;

    // One array row for weight k: Horner step for products, restoring step for divide/root.
    function automatic stage_t row_step(input stage_t s, input int k);
        stage_t      r;
        logic [16:0] trial;
        r     = s;
        trial = '0;
        case (s.mode)
            MODE_MUL, MODE_SQR: begin
                r.acc = (s.acc << 1) + (s.p[6] ? 17'(s.m) : 17'd0);
                r.p   = s.p << 1;
            end
            MODE_DIV: begin
                trial = 17'(s.m) << k;
                if (s.acc >= trial) begin
                    r.acc = s.acc - trial;
                    r.q   = s.q | (7'd1 << k);
                end
            end
            default: begin
                trial = (17'(s.q) << (k + 1)) + (17'd1 << (2 * k));
                if (s.acc >= trial) begin
                    r.acc = s.acc - trial;
                    r.q   = s.q | (7'd1 << k);
                end
            end
        endcase
        return r;
    endfunction

    stage_t      st_q [0:6];
    stage_t      st_d [0:6];
    stage_t      last;
    logic [6:0]  f_q, f_d;
    logic [14:0] s_q, s_d;
    logic [14:0] s_sum;
    logic [8:0]  bv;
    logic [13:0] av;

    always_comb begin
        bv = {<<{B}};
        av = {<<{A}};

        st_d[0]      = '0;
        st_d[0].mode = {X, (C != B)};
        st_d[0].p    = P;
`ifdef GPCA_ACCUM_EN
        st_d[0].a    = A;
`endif
        case (st_d[0].mode)
            MODE_MUL: st_d[0].m = bv;
            MODE_SQR: st_d[0].m = {2'b00, P};
            MODE_DIV: begin
                st_d[0].m   = bv;
                st_d[0].acc = {3'b000, av};
                st_d[0].ovf = (bv == 9'd0) || ({3'b000, av} >= {1'b0, bv, 7'd0});
            end
            default:  st_d[0].acc = {3'b000, A};
        endcase

        for (int i = 1; i < 7; i++) begin
            st_d[i] = row_step(st_q[i-1], 7 - i);
        end

        last = row_step(st_q[6], 0);
`ifdef GPCA_ACCUM_EN
        s_sum = last.acc[14:0] + 15'(last.a);
`else
        s_sum = last.acc[14:0];
`endif
        f_d = '0;
        s_d = s_sum;
        case (last.mode)
            MODE_DIV: begin
                f_d = last.ovf ? 7'h7F : last.q;
                s_d = last.ovf ? 15'h7FFF : last.acc[14:0];
            end
            MODE_SQRT: begin
                f_d = last.q;
                s_d = last.acc[14:0];
            end
            default: ;
        endcase
    end

    // NOTE: every stage is cleared so in-flight operations vanish on reset; a cleared
    // stage decodes as 0*0 multiply and therefore drains as zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 7; i++) begin
                st_q[i] <= '0;
            end
            f_q <= '0;
            s_q <= '0;
        end else begin
            st_q <= st_d;
            f_q  <= f_d;
            s_q  <= s_d;
        end
    end

    assign F = f_q;
    assign S = s_q;

endmodule

// File: tb/tb_gpca.sv
// Directed, table-driven bench for gpca: per-mode vectors, boundaries, streaming and mid-stream reset.
module tb_gpca;

    logic        clk = 1'b0;
    logic        rst;
    logic        X;
    logic [1:7]  P;
    logic [1:9]  B;
    logic [1:9]  C;
    logic [1:14] A;
    logic [1:7]  F;
    logic [1:15] S;

    int total = 0;
    int bad   = 0;

`ifdef GPCA_ACCUM_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    gpca u_dut (
        .clk(clk), .rst(rst), .X(X), .P(P), .B(B), .C(C), .A(A), .F(F), .S(S)
    );

    typedef struct {
        logic        x;
        logic [1:7]  p;
        logic [1:9]  b;
        logic [1:9]  c;
        logic [1:14] a;
        logic [6:0]  f;
        logic [14:0] s;
    } vec_t;

    vec_t vecs[$];
    vec_t idle;

    task automatic add_vec(input logic x, input logic [1:7] p, input logic [1:9] b,
                           input logic [1:9] c, input logic [1:14] a,
                           input logic [6:0] f, input logic [14:0] s);
        vec_t v;
        v.x = x; v.p = p; v.b = b; v.c = c; v.a = a; v.f = f; v.s = s;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        X = v.x; P = v.p; B = v.b; C = v.c; A = v.a;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx,
                         input logic [6:0] f_exp, input logic [14:0] s_exp);
        total++;
        if (F !== f_exp || S !== s_exp) begin
            bad++;
            $display("FAIL %s[%0d]: got F=%0d S=%0d, want F=%0d S=%0d",
                     name, idx, F, S, f_exp, s_exp);
        end
    endtask

    initial begin
        idle.x = 1'b0; idle.p = '0; idle.b = '0; idle.c = '0; idle.a = '0;
        idle.f = '0;   idle.s = '0;

        // Indices 0..3 are multiply, square, square-root, divide (reused for streaming).
        add_vec(1'b0, 7'b0000101, 9'b111000000, 9'b111000000, 14'b0, 7'd0, 15'd35);
        add_vec(1'b0, 7'b0000101, 9'b001111111, 9'b010000000, 14'b0, 7'd0, 15'd25);
        add_vec(1'b1, 7'b0000000, 9'b001111111, 9'b010000000, 14'b00000000011001, 7'd5, 15'd0);
        add_vec(1'b1, 7'b0000000, 9'b101000000, 9'b101000000, 14'b11000100000000, 7'd7, 15'd0);
        add_vec(1'b1, 7'b0000000, 9'b000000000, 9'b000000000, 14'b11000100000000, 7'h7F, 15'h7FFF);
        add_vec(1'b0, 7'd127, 9'h1FF, 9'h1FF, 14'b0, 7'd0, 15'd32129);
        add_vec(1'b0, 7'd127, 9'b000000001, 9'b000000000, 14'b0, 7'd0, 15'd16129);
        add_vec(1'b1, 7'd0, 9'b001111111, 9'b010000000, 14'h3FFF, 7'd127, 15'd254);
        add_vec(1'b1, 7'd0, 9'b000000001, 9'b000000000, 14'd99, 7'd9, 15'd18);
        add_vec(1'b1, 7'd0, 9'b111000000, 9'b111000000, 14'b00100110000000, 7'd14, 15'd2);
        add_vec(1'b1, 7'd0, 9'b111000000, 9'b111000000, 14'b10011110110000, 7'd127, 15'd0);
        add_vec(1'b1, 7'd0, 9'b111000000, 9'b111000000, 14'b00000001110000, 7'h7F, 15'h7FFF);
        add_vec(1'b1, 7'd0, 9'b111000000, 9'b111000000, 14'b00010111110000, 7'h7F, 15'h7FFF);
        add_vec(1'b0, 7'b0000111, 9'b101000000, 9'b101000000, 14'b00000000000011,
                7'd0, ACC_EN ? 15'd38 : 15'd35);
        add_vec(1'b0, 7'd127, 9'h1FF, 9'h1FF, 14'h3FFF, 7'd0, ACC_EN ? 15'd15744 : 15'd32129);
        add_vec(1'b0, 7'd127, 9'b000000001, 9'b000000000, 14'h3FFF,
                7'd0, ACC_EN ? 15'd32512 : 15'd16129);

        rst = 1'b1;
        drive(idle);
        tick();
        tick();
        check("reset", 0, 7'd0, 15'd0);
        rst = 1'b0;

        // Each vector: sampling edge plus 7 edges, then one more edge with inputs held.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            repeat (8) tick();
            check("vec", i, vecs[i].f, vecs[i].s);
            tick();
            check("hold", i, vecs[i].f, vecs[i].s);
        end

        // Back-to-back stream of all four modes.
        drive(idle);
        repeat (8) tick();
        check("flush", 0, 7'd0, 15'd0);
        for (int i = 0; i < 4; i++) begin
            drive(vecs[i]);
            tick();
        end
        drive(idle);
        repeat (3) tick();
        check("latency6", 0, 7'd0, 15'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stream", i, vecs[i].f, vecs[i].s);
        end
        tick();
        check("stream_idle", 0, 7'd0, 15'd0);

        // Reset mid-stream: in-flight ops and the op sampled on the reset edge are discarded.
        drive(vecs[0]);
        repeat (8) tick();
        check("pre_rst", 0, vecs[0].f, vecs[0].s);
        drive(vecs[1]);
        tick();
        drive(vecs[3]);
        tick();
        drive(vecs[2]);
        rst = 1'b1;
        tick();
        check("rst_edge", 0, 7'd0, 15'd0);
        rst = 1'b0;
        drive(vecs[3]);
        tick();
        drive(idle);
        check("post_rst", 0, 7'd0, 15'd0);
        for (int j = 1; j <= 6; j++) begin
            tick();
            check("post_rst", j, 7'd0, 15'd0);
        end
        tick();
        check("first_after_rst", 0, vecs[3].f, vecs[3].s);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpca.md
GPCA -- requirements
Module: gpca

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports clk and rst; all state SHALL change only on the rising edge of clk.
REQ-002 clk  input  1  rising-edge clock for every register.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 X  input  1  mode select: 0 = multiply/square, 1 = divide/square-root.
REQ-005 P  input  [1:7]  multiplier, unsigned; P[1] is the MSB.
REQ-006 B  input  [1:9]  multiplicand or divisor, unsigned; B[1] is the LSB.
REQ-007 C  input  [1:9]  control word; C==B selects multiply or divide; C!=B selects square or square-root.
REQ-008 A  input  [1:14]  addend or radicand (A[1] is the MSB); dividend (A[1] is the LSB).
REQ-009 F  output  [1:7]  quotient or root; F[1] is the MSB.
REQ-010 S  output  [1:15]  product, square or remainder; S[1] is the MSB.

Function
REQ-011 Operation decode, sampled with the operands on the same edge:
- X=0, C==B: multiply.
- X=0, C!=B: square.
- X=1, C==B: divide.
- X=1, C!=B: square root.
REQ-012 Multiply SHALL produce S = (P * Bv + Am) mod 2^15 and F = 0, where Bv is B read LSB-first and Am is A read MSB-first.
REQ-013 Square SHALL produce S = P*P + Am and F = 0; the result cannot exceed 15 bits.
REQ-014 Square root SHALL produce F = floor(sqrt(Am)) and S = Am - F*F, zero-extended; B and C contents beyond the C!=B decode SHALL be ignored.
REQ-015 Divide SHALL produce F = floor(Av/Bv) and S = Av - F*Bv, where Av is A read LSB-first and Bv is B read LSB-first.
REQ-016 In divide, if Bv==0 or the quotient exceeds 127, the outputs SHALL be F=7'h7F and S=15'h7FFF (overflow indication).
REQ-017 The array SHALL be pipelined as 7 row stages, one stage per P/F bit, with 1 register per row.
REQ-018 Latency SHALL be exactly 7 clk cycles from the sampling edge to the edge on which F/S update.
REQ-019 A new operation SHALL be accepted on every clock; there is no handshake or stall, and different modes may be interleaved back-to-back.
REQ-020 F and S SHALL be driven directly from registers; there is no combinational path from the inputs to the outputs.
REQ-021 Holding the inputs constant SHALL produce a constant, identical result after 7 cycles.

Reset
REQ-022 While rst=1 at a clk edge, all stage registers, F and S SHALL be cleared to 0.
REQ-023 Reset asserted mid-operation SHALL discard all in-flight operations; no partial results SHALL appear afterwards.
REQ-024 After rst deasserts, F and S SHALL stay 0 for 7 cycles, until the first post-reset operation emerges.
REQ-025 If inputs are sampled on the same edge that rst is asserted, that operation SHALL be discarded.

Configuration
REQ-026 Macro GPCA_ACCUM_EN:
- Defined: the A term (Am) SHALL be added in multiply and square modes, as in REQ-012/013.
- Undefined: A SHALL be ignored in those modes (S = P*Bv mod 2^15, or S = P*P), and the accumulate adder SHALL be removed.
- Divide and square-root behaviour SHALL be identical either way.

Verification
REQ-027 Multiply: X=0, P=0000101, B=C=111000000, A=0 -> after 7 clks S=35, F=0.
REQ-028 Square: X=0, P=0000101, B=001111111, C=010000000, A=0 -> S=25, F=0.
REQ-029 Square root: X=1, P=0, A=00000000011001, B=001111111, C=010000000 -> F=5, S=0.
REQ-030 Divide: X=1, A=11000100000000, B=C=101000000 -> F=7, S=0. Also B=C=0 -> F=7'h7F, S=15'h7FFF.
REQ-031 Stream all four operations back-to-back on consecutive clocks, then assert rst for 1 cycle mid-stream:
- Results appear on consecutive cycles starting 7 cycles after the first issue.
- F and S go to 0 on the reset edge and stay 0 for 7 cycles.
REQ-032 With GPCA_ACCUM_EN defined: multiply 7*5 with A=00000000000011 -> S=38. With the macro undefined, the same stimulus -> S=35.
